// File: rtl/fetch_if_id_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_if_id_stage_if
//   Bundles the fetch-stage signals: the hazard and branch inputs coming back
//   from ID, the instruction-memory bus, and the IF/ID register outputs.
//   clk and reset are not part of the bundle.
//
//   Signals (names match the fetch-stage port list):
//     stall, BrTaken, UncondBr, br_pc, BrAddr26, CondAddr19  -> into the stage
//     imem_addr                                              -> to instr memory
//     imem_data                                              -> from instr memory
//     pc_if, pc_id, instr_id, valid_id                       -> to ID / debug
//
//   Modports:
//     master : the fetch stage's view of the bundle
//     slave  : the surrounding core's view (hazard unit, ID, instruction memory)
// -----------------------------------------------------------------------------
interface fetch_if_id_stage_if;
    logic        stall;
    logic        BrTaken;
    logic        UncondBr;
    logic [63:0] br_pc;
    logic [25:0] BrAddr26;
    logic [18:0] CondAddr19;
    logic [63:0] imem_addr;
    logic [31:0] imem_data;
    logic [63:0] pc_if;
    logic [63:0] pc_id;
    logic [31:0] instr_id;
    logic        valid_id;

    modport master (
        input  stall, BrTaken, UncondBr, br_pc, BrAddr26, CondAddr19, imem_data,
        output imem_addr, pc_if, pc_id, instr_id, valid_id
    );

    modport slave (
        output stall, BrTaken, UncondBr, br_pc, BrAddr26, CondAddr19, imem_data,
        input  imem_addr, pc_if, pc_id, instr_id, valid_id
    );
endinterface

// File: rtl/fetch_if_id_stage.sv
// -----------------------------------------------------------------------------
// fetch_if_id_stage
//   Instruction-fetch stage and IF/ID pipeline register of the AArch64 core.
//   Holds the PC, drives the combinational instruction-memory address,
//   selects the next PC from sequential flow or a branch resolved in ID, and
//   registers the fetched instruction and its PC for the ID stage.
//
//   Ports:
//     clk    : core clock, all state updates on the rising edge
//     reset  : synchronous, active-high; overrides every other input
//     bus    : fetch_if_id_stage_if.master (stall/branch inputs, imem bus,
//              pc_if, pc_id, instr_id, valid_id)
//
//   Parameters:
//     RESET_PC  : PC loaded on reset
//     NOP_INSTR : bubble instruction word (decodes to all-zero controls)
//
//   Build option:
//     BRANCH_DELAY_SLOT_EN : when defined, the instruction fetched in the cycle
//     a branch is taken is kept in IF/ID (one-instruction delay slot); when
//     undefined it is squashed to a NOP_INSTR bubble. The PC update is the
//     same in both builds.
//
//   Update priority per cycle: reset > stall > BrTaken > sequential.
// -----------------------------------------------------------------------------
module fetch_if_id_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                reset,
    fetch_if_id_stage_if.master bus
);

    logic [63:0] pc_q,       pc_d;
    logic [63:0] pc_id_q,    pc_id_d;
    logic [31:0] instr_id_q, instr_id_d;
    logic        valid_id_q, valid_id_d;

    logic [63:0] br_offset;
    logic [63:0] br_target;
    logic [63:0] pc_seq;

    // Word offsets are sign-extended to 64 bits, then scaled to bytes; the
    // additions wrap modulo 2^64 by construction of the 64-bit result.
    always_comb begin
        if (bus.UncondBr) begin
            br_offset = {{38{bus.BrAddr26[25]}}, bus.BrAddr26};
        end else begin
            br_offset = {{45{bus.CondAddr19[18]}}, bus.CondAddr19};
        end
        br_target = bus.br_pc + (br_offset << 2);
        pc_seq    = pc_q + 64'd4;
    end

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // through the if/else leaves a signal unassigned and infers a latch.
        pc_d       = pc_q;
        pc_id_d    = pc_id_q;
        instr_id_d = instr_id_q;
        valid_id_d = valid_id_q;

        // A stalled cycle holds everything; the branch in ID stays put and
        // re-asserts BrTaken once the stall is released.
        if (!bus.stall) begin
            if (bus.BrTaken) begin
                pc_d    = br_target;
                pc_id_d = pc_q;
`ifdef BRANCH_DELAY_SLOT_EN
                instr_id_d = bus.imem_data;
                valid_id_d = 1'b1;
`else
                instr_id_d = NOP_INSTR;
                valid_id_d = 1'b0;
`endif
            end else begin
                pc_d       = pc_seq;
                pc_id_d    = pc_q;
                instr_id_d = bus.imem_data;
                valid_id_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops
    // sample their _d values from the same edge regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q       <= RESET_PC;
            pc_id_q    <= 64'h0;
            instr_id_q <= NOP_INSTR;
            valid_id_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pc_id_q    <= pc_id_d;
            instr_id_q <= instr_id_d;
            valid_id_q <= valid_id_d;
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.pc_if     = pc_q;
    assign bus.pc_id     = pc_id_q;
    assign bus.instr_id  = instr_id_q;
    assign bus.valid_id  = valid_id_q;

endmodule

// File: doc/fetch_if_id_stage.md
Name: fetch_if_id_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register of the pipelined AArch64 core.
- Holds the PC, drives the combinational instruction memory address, and computes the next PC from sequential flow or a branch resolved in ID.
- Presents the registered instruction and PC to the ID stage; the control decoder reads its opcode field instr_id[31:21].
- Implements stall (hold) from the hazard unit and flush (bubble) on taken branches.

Parameters:
- RESET_PC, 64'h0, PC value loaded on reset.
- NOP_INSTR, 32'h00000000, instruction word injected as a bubble; the control decoder maps it to all-zero controls (no write, no branch).

Ports:
- clk  input  1  core clock, all state on rising edge
- reset  input  1  synchronous, active-high reset
- stall  input  1  hazard unit hold request; freezes PC and IF/ID register
- BrTaken  input  1  branch taken, resolved in ID this cycle
- UncondBr  input  1  1 = use BrAddr26 offset, 0 = use CondAddr19 offset
- br_pc  input  64  PC of the branch instruction currently in ID (equals pc_id)
- BrAddr26  input  26  instr_id[25:0] word offset for B
- CondAddr19  input  19  instr_id[23:5] word offset for B.cond/CBZ
- imem_addr  output  64  address to instruction memory (combinational read)
- imem_data  input  32  instruction word returned same cycle
- pc_if  output  64  current fetch PC (debug/observability)
- pc_id  output  64  registered PC of instruction in ID
- instr_id  output  32  registered instruction in ID
- valid_id  output  1  1 = instr_id is a real fetched instruction, 0 = bubble

Behaviour:
- Reset (synchronous, checked at rising edge, overrides all other inputs): PC <= RESET_PC; instr_id <= NOP_INSTR; pc_id <= 0; valid_id <= 0. Reset asserted mid-stream discards the in-flight IF/ID contents. The first fetch at RESET_PC reaches ID one cycle after reset deasserts.
- imem_addr = pc_if = PC, combinational from the PC register.
- Branch target = br_pc + (sign_extend_64(offset) << 2), arithmetic mod 2^64 (wrap, no flag). offset is BrAddr26 when UncondBr=1, else CondAddr19.
- Sequential next PC = PC + 4, mod 2^64.
- Per-cycle update, priority reset > stall > BrTaken > normal:
  - stall=1: PC, pc_id, instr_id, valid_id all hold. BrTaken is ignored this cycle; the stalled branch re-asserts it when stall drops.
  - stall=0, BrTaken=1: PC <= branch target. IF/ID per Optional Feature.
  - stall=0, BrTaken=0: PC <= PC+4; instr_id <= imem_data; pc_id <= PC; valid_id <= 1.
- Latency: an instruction fetched at PC in cycle N appears on instr_id/pc_id in cycle N+1. A taken branch in ID in cycle N gives fetch of the target in cycle N+1, with the target in ID in cycle N+2.
- No internal FSM beyond PC and valid. Back-to-back taken branches are each handled independently.
- Outputs are registered except imem_addr and pc_if (direct from the PC register).

Optional Feature:
- Macro BRANCH_DELAY_SLOT_EN.
- Defined: on a taken branch, the instruction fetched in the same cycle (at PC) is still loaded into IF/ID (instr_id <= imem_data, pc_id <= PC, valid_id <= 1), giving a one-instruction delay slot.
- Undefined (default): on a taken branch, IF/ID loads instr_id <= NOP_INSTR, pc_id <= PC, valid_id <= 0, squashing the wrong-path instruction.
- PC update is identical in both builds.

Test Plan:
- Reset for 2 cycles, then release with a memory returning word = addr: imem_addr goes 0,4,8,C; instr_id lags by one cycle (0,4,8); valid_id=0 during reset and 1 from the first post-reset edge.
- Stall held 3 cycles at PC=0x10: PC, instr_id and pc_id are frozen; on release, PC advances to 0x14 and IF/ID loads the word at 0x10.
- Unconditional branch with br_pc=0x20, UncondBr=1, BrAddr26=26'h3FFFFFE (-2): next PC=0x18; default build gives instr_id=0, valid_id=0; delay-slot build loads the word at PC.
- Conditional branch with br_pc=0x100, UncondBr=0, CondAddr19=19'h00004: next PC=0x110.
- Simultaneous stall=1 and BrTaken=1: no state change. The following cycle with stall=0 and BrTaken=1 redirects to the target.
- reset=1 asserted while a branch is taken and stall=1: PC=RESET_PC, valid_id=0 on the next edge.
- Wrap-around: PC=64'hFFFF_FFFF_FFFF_FFFC advances to 0.
